// File: rtl/cadr_trace_monitor.sv
// cadr_trace_monitor: circular {lpc, ir} trace capture with fault/external trigger, post window and oldest-first drain
module cadr_trace_monitor #(
    parameter int PC_WIDTH    = 14,
    parameter int IR_WIDTH    = 49,
    parameter int DEPTH_LOG2  = 8,
    parameter int POST_TRIG   = 16,
    parameter int CYC_WIDTH   = 32,
    parameter int LIMIT_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         fetch,
    input  logic [PC_WIDTH-1:0]          lpc,
    input  logic [IR_WIDTH-1:0]          ir,
    input  logic                         arm,
    input  logic                         ext_trig,
    input  logic [PC_WIDTH-1:0]          fault_pc,
    input  logic [LIMIT_WIDTH-1:0]       fault_limit,
    input  logic                         rd_ready,
    output logic                         rd_valid,
    output logic [PC_WIDTH+IR_WIDTH-1:0] rd_data,
    output logic                         triggered,
    output logic                         frozen,
    output logic [DEPTH_LOG2:0]          entries,
    output logic [LIMIT_WIDTH-1:0]       fault_count,
    output logic [CYC_WIDTH-1:0]         cycles
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW = POST_TRIG > 0 ? $clog2(POST_TRIG + 1) : 1;

    typedef enum logic [1:0] {IDLE, ARMED, POST, FROZEN} state_t;

    state_t                        state_q, state_d;
    logic [DEPTH_LOG2-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr;
    logic [DEPTH_LOG2:0]           entries_q, entries_d;
    logic [LIMIT_WIDTH-1:0]        fault_count_q, fault_count_d;
    logic [CYC_WIDTH-1:0]          cycles_q, cycles_d;
    logic                          triggered_q, triggered_d;
    logic [PW-1:0]                 post_q, post_d;
    logic                          capture, hit, trig;
    logic [PC_WIDTH+IR_WIDTH-1:0]  mem [DEPTH];

    always_comb begin
        capture = !arm && fetch && (state_q == ARMED || state_q == POST);
        hit = capture && lpc == fault_pc;
        // a saturated fault_count can never be raised, so it cannot fire the trigger
        trig = !arm && state_q == ARMED &&
               (ext_trig || (hit && fault_count_q == fault_limit && ~&fault_count_q));
        rd_ptr = wr_ptr_q - entries_q[DEPTH_LOG2-1:0];
        rd_valid = state_q == FROZEN && entries_q != '0;
        state_d = state_q;
        wr_ptr_d = capture ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
        entries_d = capture && !entries_q[DEPTH_LOG2] ? entries_q + (DEPTH_LOG2+1)'(1) : entries_q;
        cycles_d = capture && ~&cycles_q ? cycles_q + CYC_WIDTH'(1) : cycles_q;
        fault_count_d = hit && ~&fault_count_q ? fault_count_q + LIMIT_WIDTH'(1) : fault_count_q;
        triggered_d = triggered_q || trig;
        post_d = post_q;
        case (state_q)
            ARMED: if (trig) begin
                if (POST_TRIG == 0) state_d = FROZEN;
                else state_d = POST;
                post_d = PW'(POST_TRIG);
            end
            POST: if (capture) begin
                post_d = post_q - PW'(1);
                if (post_q == PW'(1)) state_d = FROZEN;
            end
            FROZEN: if (rd_valid && rd_ready) entries_d = entries_q - (DEPTH_LOG2+1)'(1);
            default: ;
        endcase
        if (arm) begin
            state_d = ARMED;
            wr_ptr_d = '0;
            entries_d = '0;
            cycles_d = '0;
            fault_count_d = '0;
            triggered_d = 1'b0;
            post_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            wr_ptr_q <= '0;
            entries_q <= '0;
            cycles_q <= '0;
            fault_count_q <= '0;
            triggered_q <= 1'b0;
            post_q <= '0;
        end else begin
            state_q <= state_d;
            wr_ptr_q <= wr_ptr_d;
            entries_q <= entries_d;
            cycles_q <= cycles_d;
            fault_count_q <= fault_count_d;
            triggered_q <= triggered_d;
            post_q <= post_d;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) mem[wr_ptr_q] <= {lpc, ir};
    end

    assign rd_data = mem[rd_ptr];
    assign triggered = triggered_q;
    assign frozen = state_q == FROZEN;
    assign entries = entries_q;
    assign fault_count = fault_count_q;
    assign cycles = cycles_q;
endmodule

// File: doc/cadr_trace_monitor.md
# cadr_trace_monitor

Synthesizable, parametrised CPU execution-trace monitor for the CADR core in the uhdl designs. It captures `{lpc, ir}` on every instruction-fetch strobe into a circular buffer and counts executed instructions. It raises a trigger after a programmable number of hits on a fault PC, or on an external request, then captures a programmable post-trigger window and freezes. The frozen history is drained oldest-first over a valid/ready port, so on-board debug gets the same fault trace the simulation bench prints.

## Interface

Parameters:
- `PC_WIDTH`, 14: width of `lpc` and `fault_pc`.
- `IR_WIDTH`, 49: width of the captured instruction register.
- `DEPTH_LOG2`, 8: buffer depth is DEPTH = 2^DEPTH_LOG2 entries.
- `POST_TRIG`, 16: fetches captured after the trigger fetch; 0 is legal.
- `CYC_WIDTH`, 32: instruction counter width.
- `LIMIT_WIDTH`, 8: width of `fault_limit` and `fault_count`.

Ports:
- `clk`, in, 1: CPU clock; all state is on its rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `fetch`, in, 1: one-cycle strobe per executed instruction, asserted in CPU state 6'b000001.
- `lpc`, in, PC_WIDTH: PC of the fetched instruction.
- `ir`, in, IR_WIDTH: the fetched instruction.
- `arm`, in, 1: pulse that clears the monitor and starts capture.
- `ext_trig`, in, 1: external trigger request.
- `fault_pc`, in, PC_WIDTH: PC to watch (codebase default 14'o26).
- `fault_limit`, in, LIMIT_WIDTH: trigger fires on hit number fault_limit+1 (default 5).
- `rd_ready`, in, 1: consumer accepts `rd_data`.
- `rd_valid`, out, 1: `rd_data` holds an unread frozen entry.
- `rd_data`, out, PC_WIDTH+IR_WIDTH: `{lpc, ir}` of the oldest unread entry.
- `triggered`, out, 1: trigger has fired since the last `arm`.
- `frozen`, out, 1: state is FROZEN.
- `entries`, out, DEPTH_LOG2+1: number of valid or unread entries.
- `fault_count`, out, LIMIT_WIDTH: fault-PC hits since `arm`, saturating.
- `cycles`, out, CYC_WIDTH: fetches counted since `arm`, saturating.

## Operation

- States:
  - IDLE: no capture.
  - ARMED: capture, watch for the trigger.
  - POST: capture the post-trigger window.
  - FROZEN: capture stopped, readout enabled.
- `arm`, in any state, has priority over all other events.
  - Clears `wr_ptr`, `entries`, `fault_count`, `cycles`, `triggered` and the post counter.
  - Next state is ARMED.
  - A `fetch` in the same cycle is ignored.
- Capture (ARMED or POST, on `fetch`):
  - Write `{lpc, ir}` at `wr_ptr`; `wr_ptr` wraps mod DEPTH.
  - `entries` increments and saturates at DEPTH; once full, the oldest entry is overwritten.
  - `cycles` increments and saturates at all-ones.
- Fault hit (ARMED or POST, `fetch` && `lpc == fault_pc`): `fault_count` increments and saturates.
- Trigger, evaluated in ARMED only. Either condition fires it:
  - `ext_trig` is high, or
  - a fault-hit fetch raises `fault_count` to fault_limit+1.
- When the trigger fires:
  - `triggered` is set.
  - If the trigger coincides with a fetch, that fetch is captured.
  - With POST_TRIG = 0, go to FROZEN; otherwise load the post counter with POST_TRIG and go to POST.
- POST: each fetch is captured and decrements the post counter. The fetch that brings it to 0 moves the state to FROZEN. `ext_trig` is ignored.
- FROZEN:
  - `rd_valid = (entries != 0)`.
  - `rd_data` = entry at `rd_ptr = wr_ptr - entries` (mod DEPTH), read combinationally; distributed RAM is acceptable.
  - When `rd_valid && rd_ready`: `entries` decrements. `rd_data` then shows the next-oldest entry.
  - `fetch` and `ext_trig` are ignored.
  - The state stays FROZEN until `arm`.

## Timing

- After reset:
  - State is IDLE; all counters and pointers are 0.
  - `rd_valid`, `triggered` and `frozen` are 0.
  - `rd_data` is don't-care.
- Capture latency is 1 cycle: a fetch in cycle N is counted in `entries` and `cycles` in cycle N+1.
- The trigger fetch is at cycle T. `frozen` rises at cycle T+1 when POST_TRIG = 0, otherwise 1 cycle after the POST_TRIG-th subsequent fetch.
- Readout runs at one entry per cycle while `rd_ready` is held high. `rd_valid` drops in the cycle after the last entry is accepted.
- `arm` during FROZEN mid-drain discards the unread entries immediately; `rd_valid` is 0 on the next cycle.
- When `reset_n` is asserted mid-operation, all state is lost asynchronously and behaviour is identical to power-up.

## Test plan

- Counting and fault trigger, POST_TRIG=0, fault_pc=14'o26, fault_limit=5.
  - Stimulus: after `arm`, 20 fetches whose 6th hit on 14'o26 falls at fetch index 17.
  - Required: `triggered` and then `frozen` at the next cycle; `cycles`=17; `fault_count`=6; `entries`=17.
  - Draining returns `lpc` values in issue order, ending at 14'o26; fetches 18-20 are absent.
- Wrap-around, DEPTH_LOG2=4.
  - Stimulus: 40 fetches with `lpc` = 0..39, then `ext_trig`.
  - Required: `entries`=16; drained `lpc` values are 24..39.
- Post window, POST_TRIG=3.
  - Stimulus: `ext_trig` together with the fetch of `lpc`=10, followed by fetches with `lpc` 11-15.
  - Required: `frozen` goes high after `lpc`=13; the last drained entry is 13.
- Backpressure.
  - Stimulus: toggle `rd_ready` every cycle while draining 8 entries.
  - Required: exactly 8 handshakes, order preserved, and `rd_data` is stable while `rd_ready`=0.
- Arm priority.
  - Stimulus: in FROZEN with 5 unread entries, assert `arm` together with a fetch.
  - Required: next cycle shows ARMED, `entries`=0, `cycles`=0 and `rd_valid`=0.
- Async reset.
  - Stimulus: drop `reset_n` mid-POST, between clock edges.
  - Required: `frozen`, `triggered` and `entries` are 0 immediately, before the next clock edge.
